// File: rtl/uart_prog_loader.sv
// uart_prog_loader
//   Receiving end of the serial program download link. Deserialises 8N1 UART
//   bytes, packs four bytes MSB-first into a 32-bit instruction word and writes
//   each word to consecutive instruction-memory word addresses until the
//   terminator word arrives or the address space is full.
//
// Ports
//   clk_i         single clock
//   rst_i         asynchronous, active-high reset
//   en_i          level enable; low aborts any byte in flight
//   rx_i          serial data, idles high
//   prog_ready_o  registered en_i & ~done_o, gates the host-side sender
//   we_o          one-cycle instruction-memory write strobe
//   addr_o        write word address
//   wdata_o       write data
//   done_o        sticky, load finished
//   frame_err_o   sticky, a stop bit was sampled low
//   timeout_o     sticky, inter-byte timeout (only with LOADER_WDT_EN)
//
// Build option
//   LOADER_WDT_EN  adds the inter-byte watchdog, the TIMEOUT_BITS parameter and
//                  the timeout_o port. Without it a partial word waits forever.

module uart_prog_loader #(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned ADDR_WIDTH   = 14,
    parameter logic [31:0] TERM_WORD    = 32'h00000FFF
`ifdef LOADER_WDT_EN
    , parameter int unsigned TIMEOUT_BITS = 32
`endif
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  rx_i,
    output logic                  prog_ready_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [31:0]           wdata_o,
    output logic                  done_o,
    output logic                  frame_err_o
`ifdef LOADER_WDT_EN
    , output logic                timeout_o
`endif
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    // Synchroniser and edge-detect flops reset to the idle (high) line level
    // so that leaving reset never looks like a start-bit edge.
    logic rx_s1_q, rx_s2_q, rx_prev_q;
    logic rx_sync;

    logic [2:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            shreg_q, shreg_d;
    logic [1:0]            idx_q, idx_d;
    logic [31:0]           word_q, word_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic                  done_q, done_d;
    logic                  ferr_q, ferr_d;
    logic                  ready_q;

    logic        active;
    logic        byte_ok;
    logic        frame_bad;
    logic [31:0] word_next;

`ifdef LOADER_WDT_EN
    localparam logic [31:0] WDT_LAST = 32'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
    logic [31:0] wdt_q, wdt_d;
    logic        tmo_q, tmo_d;
`endif

    assign rx_sync   = rx_s2_q;
    assign active    = en_i & ~done_q;
    assign word_next = {word_q[23:0], shreg_q};

    // Byte receiver
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        byte_ok   = 1'b0;
        frame_bad = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_sync) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx_sync) begin
                        state_d = S_DATA;
                        bit_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {rx_sync, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_sync) begin
                        byte_ok = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_d   = S_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                // Need one full bit period of continuous high before re-arming.
                if (!rx_sync) begin
                    cnt_d = '0;
                end else if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (!active) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            byte_ok   = 1'b0;
            frame_bad = 1'b0;
        end
    end

    // Word assembly and memory write
    always_comb begin
        idx_d   = idx_q;
        word_d  = word_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        done_d  = done_q;
        ferr_d  = ferr_q;
`ifdef LOADER_WDT_EN
        wdt_d   = wdt_q;
        tmo_d   = tmo_q;
`endif

        // Address advances the cycle after the strobe; it saturates at the top.
        if (we_q && (addr_q != '1)) begin
            addr_d = addr_q + 1'b1;
        end

        if (!en_i) begin
            idx_d  = '0;
            word_d = '0;
        end else if (frame_bad) begin
            ferr_d = 1'b1;
            idx_d  = '0;
            word_d = '0;
        end else if (byte_ok) begin
            word_d = word_next;
            idx_d  = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
                if (word_next == TERM_WORD) begin
                    done_d = 1'b1;
                end else begin
                    we_d    = 1'b1;
                    wdata_d = word_next;
                    if (addr_q == '1) begin
                        done_d = 1'b1;
                    end
                end
            end
        end

`ifdef LOADER_WDT_EN
        if (!en_i || (idx_q == 2'd0) || byte_ok || frame_bad) begin
            wdt_d = '0;
        end else if (wdt_q == WDT_LAST) begin
            wdt_d  = '0;
            tmo_d  = 1'b1;
            idx_d  = '0;
            word_d = '0;
        end else begin
            wdt_d = wdt_q + 32'd1;
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            idx_q     <= '0;
            word_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ready_q   <= 1'b0;
`ifdef LOADER_WDT_EN
            wdt_q     <= '0;
            tmo_q     <= 1'b0;
`endif
        end else begin
            rx_s1_q   <= rx_i;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            idx_q     <= idx_d;
            word_q    <= word_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
            ready_q   <= en_i & ~done_q;
`ifdef LOADER_WDT_EN
            wdt_q     <= wdt_d;
            tmo_q     <= tmo_d;
`endif
        end
    end

    assign prog_ready_o = ready_q;
    assign we_o         = we_q;
    assign addr_o       = addr_q;
    assign wdata_o      = wdata_q;
    assign done_o       = done_q;
    assign frame_err_o  = ferr_q;
`ifdef LOADER_WDT_EN
    assign timeout_o    = tmo_q;
`endif

endmodule

// File: tb/tb_uart_prog_loader.sv
`timescale 1ns/1ps

module tb_uart_prog_loader;

    localparam int unsigned CPB = 87;
    localparam int unsigned AW  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic          rx  = 1'b1;
    logic          prog_ready;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          done;
    logic          ferr;
`ifdef LOADER_WDT_EN
    logic          tmo;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Write log filled by the monitor
    int unsigned nw = 0;
    int unsigned wide = 0;
    int unsigned base = 0;
    logic        we_prev = 1'b0;
    logic [31:0] log_a [16];
    logic [31:0] log_d [16];

    uart_prog_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_WIDTH  (AW),
        .TERM_WORD   (32'h00000FFF)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .rx_i        (rx),
        .prog_ready_o(prog_ready),
        .we_o        (we),
        .addr_o      (addr),
        .wdata_o     (wdata),
        .done_o      (done),
        .frame_err_o (ferr)
`ifdef LOADER_WDT_EN
        , .timeout_o (tmo)
`endif
    );

    always #50 clk = ~clk;

    always @(negedge clk) begin
        if (we) begin
            log_a[nw % 16] = 32'(addr);
            log_d[nw % 16] = wdata;
            nw = nw + 1;
            if (we_prev) wide = wide + 1;
        end
        we_prev = we;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        assert (got === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok, input int unsigned stretch);
        @(posedge clk);
        rx = 1'b0;
        repeat (CPB + stretch) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        rx = stop_ok;
        repeat (CPB) @(posedge clk);
        rx = 1'b1;
        repeat (stop_ok ? CPB : 2 * CPB) @(posedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int unsigned stretch);
        send_byte(w[31:24], 1'b1, stretch);
        send_byte(w[23:16], 1'b1, stretch);
        send_byte(w[15:8],  1'b1, stretch);
        send_byte(w[7:0],   1'b1, stretch);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(prog_ready), 32'd0);
        chk("rst_we",    32'(we),         32'd0);
        chk("rst_addr",  32'(addr),       32'd0);
        chk("rst_wdata", wdata,           32'd0);
        chk("rst_done",  32'(done),       32'd0);
        chk("rst_ferr",  32'(ferr),       32'd0);
`ifdef LOADER_WDT_EN
        chk("rst_tmo",   32'(tmo),        32'd0);
`endif
        rst = 1'b0;
        en  = 1'b1;
        repeat (2) @(negedge clk);
        chk("ready_after_en", 32'(prog_ready), 32'd1);

        // Two words then terminator
        base = nw;
        send_word(32'h00000013, 0);
        send_word(32'hDEADBEEF, 0);
        send_word(32'h00000FFF, 0);
        @(negedge clk);
        chk("t1_nwrites", nw - base,        32'd2);
        chk("t1_addr0",   log_a[base % 16], 32'd0);
        chk("t1_data0",   log_d[base % 16], 32'h00000013);
        chk("t1_addr1",   log_a[(base + 1) % 16], 32'd1);
        chk("t1_data1",   log_d[(base + 1) % 16], 32'hDEADBEEF);
        chk("t1_done",    32'(done),        32'd1);
        chk("t1_ready",   32'(prog_ready),  32'd0);
        chk("t1_addr_o",  32'(addr),        32'd2);
        send_word(32'h01020304, 0);
        chk("t1_ignored", nw - base,        32'd2);

        // Frame error, then a clean word
        do_reset();
        base = nw;
        send_byte(8'hA5, 1'b0, 0);
        chk("t2_ferr", 32'(ferr), 32'd1);
        send_word(32'h11223344, 0);
        @(negedge clk);
        chk("t2_nwrites", nw - base,        32'd1);
        chk("t2_addr0",   log_a[base % 16], 32'd0);
        chk("t2_data0",   log_d[base % 16], 32'h11223344);
        chk("t2_addr_o",  32'(addr),        32'd1);
        chk("t2_done",    32'(done),        32'd0);
        chk("t2_ready",   32'(prog_ready),  32'd1);

        // Asynchronous reset during the data bits of the 3rd byte
        send_byte(8'hAA, 1'b1, 0);
        send_byte(8'hBB, 1'b1, 0);
        @(posedge clk);
        rx = 1'b0;
        repeat (3 * CPB) @(posedge clk);
        #10 rst = 1'b1;
        #1;
        chk("t3_ready", 32'(prog_ready), 32'd0);
        chk("t3_we",    32'(we),         32'd0);
        chk("t3_addr",  32'(addr),       32'd0);
        chk("t3_wdata", wdata,           32'd0);
        chk("t3_done",  32'(done),       32'd0);
        chk("t3_ferr",  32'(ferr),       32'd0);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        base = nw;
        send_word(32'hCAFEBABE, 0);
        @(negedge clk);
        chk("t3_nwrites", nw - base,        32'd1);
        chk("t3_addr0",   log_a[base % 16], 32'd0);
        chk("t3_data0",   log_d[base % 16], 32'hCAFEBABE);

        // Idle glitch of 0.3 bit, then stretched start bits (1000 ns)
        @(posedge clk);
        rx = 1'b0;
        repeat (26) @(posedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        base = nw;
        send_word(32'h01020304, 10);
        @(negedge clk);
        chk("t4_nwrites", nw - base,        32'd1);
        chk("t4_addr",    log_a[base % 16], 32'd1);
        chk("t4_data",    log_d[base % 16], 32'h01020304);

        // Fill to the last address: done with the final write, no wrap
        base = nw;
        send_word(32'h05060708, 0);
        send_word(32'h090A0B0C, 0);
        @(negedge clk);
        chk("t5_nwrites", nw - base,        32'd2);
        chk("t5_addr2",   log_a[base % 16], 32'd2);
        chk("t5_addr3",   log_a[(base + 1) % 16], 32'd3);
        chk("t5_data3",   log_d[(base + 1) % 16], 32'h090A0B0C);
        chk("t5_done",    32'(done),        32'd1);
        chk("t5_addr_o",  32'(addr),        32'd3);
        chk("t5_ready",   32'(prog_ready),  32'd0);
        chk("we_width",   wide,             32'd0);

        // Terminator as the first word
        do_reset();
        base = nw;
        send_word(32'h00000FFF, 0);
        @(negedge clk);
        chk("t6_nwrites", nw - base,       32'd0);
        chk("t6_done",    32'(done),       32'd1);
        chk("t6_addr_o",  32'(addr),       32'd0);
        chk("t6_ready",   32'(prog_ready), 32'd0);

`ifdef LOADER_WDT_EN
        // Two bytes, 40 idle bit periods, then a full word
        do_reset();
        base = nw;
        send_byte(8'h12, 1'b1, 0);
        send_byte(8'h34, 1'b1, 0);
        repeat (40 * CPB) @(posedge clk);
        @(negedge clk);
        chk("t7_tmo", 32'(tmo), 32'd1);
        send_word(32'h44556677, 0);
        @(negedge clk);
        chk("t7_nwrites", nw - base,        32'd1);
        chk("t7_addr0",   log_a[base % 16], 32'd0);
        chk("t7_data0",   log_d[base % 16], 32'h44556677);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
